// File: rtl/mont_pkg.sv
// mont_pkg: shared types and constants for the Montgomery multiplication controller.
//   mont_state_e : controller FSM states
//   ADD_W        : operand width on the shared adder port
//   ADD_RES_W    : adder result width (bit ADD_W is the carry-out)
//   K_DEFAULT    : default operand width in bits
package mont_pkg;

  localparam int unsigned ADD_W     = 514;
  localparam int unsigned ADD_RES_W = 515;
  localparam int unsigned K_DEFAULT = 512;

  typedef enum logic [3:0] {
    StIdle,
    StLoad,
    StIssueB,
    StWaitB,
    StIssueM,
    StWaitM,
    StIssueSub,
    StWaitSub,
    StDone
  } mont_state_e;

endpackage

// File: rtl/mont_mul_ctrl.sv
// mont_mul_ctrl: bit-serial radix-2 Montgomery multiplication controller.
// Computes result = in_a * in_b * 2^-K mod in_m. All wide additions and subtractions are
// issued to an external multi-cycle adder through the add_start/add_done handshake; this
// block only sequences them and holds the state registers.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   start                 one-cycle request, honoured only when idle
//   in_a, in_b, in_m      operands (K bits), sampled with start
//   result, done          product (held until next start) and one-cycle completion pulse
//   add_start             one-cycle adder request
//   add_subtract          1 selects add_in_a - add_in_b
//   add_shift             unused adder mode, tied 0
//   add_in_a, add_in_b    adder operands, held from add_start until add_done
//   add_result, add_done  adder sum (bit 514 = carry-out) and completion pulse
//
// Build option: MONT_SKIP_ZERO_EN skips additions whose addend is zero (one cycle each, no
// add_start), making latency data-dependent. Leave undefined for constant-time operation.
module mont_mul_ctrl
  import mont_pkg::*;
#(
  parameter int unsigned K = K_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [K-1:0]         in_a,
  input  logic [K-1:0]         in_b,
  input  logic [K-1:0]         in_m,
  output logic [K-1:0]         result,
  output logic                 done,
  output logic                 add_start,
  output logic                 add_subtract,
  output logic                 add_shift,
  output logic [ADD_W-1:0]     add_in_a,
  output logic [ADD_W-1:0]     add_in_b,
  input  logic [ADD_RES_W-1:0] add_result,
  input  logic                 add_done
);

`ifdef MONT_SKIP_ZERO_EN
  localparam bit SkipZero = 1'b1;
`else
  localparam bit SkipZero = 1'b0;
`endif

  localparam int unsigned IW = $clog2(K);

  mont_state_e      state_q;
  logic [ADD_W-1:0] c_q;
  logic [K-1:0]     a_q;
  logic [K-1:0]     b_q;
  logic [K-1:0]     m_q;
  logic [IW-1:0]    i_q;

  logic [ADD_W-1:0] c_nxt;
  logic [K-1:0]     a_nxt;
  logic [ADD_W-1:0] b_term;
  logic [ADD_W-1:0] m_term;
  logic             issue_b_nxt;
  logic             issue_m_nxt;
  logic             b_step;
  logic             m_step;
  logic             last_iter;

  assign add_shift = 1'b0;

  // C and A as they will be after the step completing this cycle; the operands of the next
  // ISSUE state are derived from these so they are registered and ready on entry.
  always_comb begin
    c_nxt = c_q;
    a_nxt = a_q;
    unique case (state_q)
      StWaitB: c_nxt = add_result[ADD_W-1:0];
      StIssueM: begin
        // Only used when the M addition is skipped: C is even, halve directly.
        c_nxt = c_q >> 1;
        a_nxt = a_q >> 1;
      end
      StWaitM: begin
        c_nxt = add_result[ADD_RES_W-1:1];
        a_nxt = a_q >> 1;
      end
      default: ;
    endcase
    b_term      = a_nxt[0] ? ADD_W'(b_q) : '0;
    m_term      = c_nxt[0] ? ADD_W'(m_q) : '0;
    issue_b_nxt = !SkipZero || a_nxt[0];
    issue_m_nxt = !SkipZero || c_nxt[0];
    // A skipped ISSUE state is recognised by add_start being low while in it.
    b_step      = (state_q == StIssueB && !add_start) || (state_q == StWaitB && add_done);
    m_step      = (state_q == StIssueM && !add_start) || (state_q == StWaitM && add_done);
    last_iter   = (i_q == IW'(K - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      c_q          <= '0;
      a_q          <= '0;
      b_q          <= '0;
      m_q          <= '0;
      i_q          <= '0;
      result       <= '0;
      done         <= 1'b0;
      add_start    <= 1'b0;
      add_subtract <= 1'b0;
      add_in_a     <= '0;
      add_in_b     <= '0;
    end else begin
      done      <= 1'b0;
      add_start <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_q     <= in_a;
            b_q     <= in_b;
            m_q     <= in_m;
            c_q     <= '0;
            i_q     <= '0;
            state_q <= StLoad;
          end
        end
        StLoad: begin
          add_subtract <= 1'b0;
          add_in_a     <= c_nxt;
          add_in_b     <= b_term;
          add_start    <= issue_b_nxt;
          state_q      <= StIssueB;
        end
        StIssueB, StWaitB: begin
          if (b_step) begin
            c_q       <= c_nxt;
            add_in_a  <= c_nxt;
            add_in_b  <= m_term;
            add_start <= issue_m_nxt;
            state_q   <= StIssueM;
          end else if (state_q == StIssueB) begin
            state_q <= StWaitB;
          end
        end
        StIssueM, StWaitM: begin
          if (m_step) begin
            c_q      <= c_nxt;
            a_q      <= a_nxt;
            i_q      <= i_q + 1'b1;
            add_in_a <= c_nxt;
            if (last_iter) begin
              // Final conditional subtraction: C - M, carry-out set means C >= M.
              add_subtract <= 1'b1;
              add_in_b     <= ADD_W'(m_q);
              add_start    <= 1'b1;
              state_q      <= StIssueSub;
            end else begin
              add_in_b  <= b_term;
              add_start <= issue_b_nxt;
              state_q   <= StIssueB;
            end
          end else if (state_q == StIssueM) begin
            state_q <= StWaitM;
          end
        end
        StIssueSub: state_q <= StWaitSub;
        StWaitSub: begin
          if (add_done) begin
            result  <= add_result[ADD_RES_W-1] ? add_result[K-1:0] : c_q[K-1:0];
            done    <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          add_subtract <= 1'b0;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_mul_ctrl.sv
// tb_mont_mul_ctrl: self-checking bench for mont_mul_ctrl. Drives a K=4 instance and a
// K=512 instance, each beside a behavioural adder with fixed latency L, and compares the
// products against a modular-arithmetic reference.
module tb_mont_mul_ctrl;
  import mont_pkg::*;

  localparam int L  = 4;
  localparam int KS = 4;
  localparam int KW = 512;

`ifdef MONT_SKIP_ZERO_EN
  localparam bit TbSkip = 1'b1;
`else
  localparam bit TbSkip = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // K = 4 instance
  logic                 start, done, add_start, add_subtract, add_shift, add_done;
  logic [KS-1:0]        in_a, in_b, in_m, result;
  logic [ADD_W-1:0]     add_in_a, add_in_b;
  logic [ADD_RES_W-1:0] add_result;

  // K = 512 instance
  logic                 w_start, w_done, w_add_start, w_add_subtract, w_add_shift, w_add_done;
  logic [KW-1:0]        w_in_a, w_in_b, w_in_m, w_result;
  logic [ADD_W-1:0]     w_add_in_a, w_add_in_b;
  logic [ADD_RES_W-1:0] w_add_result;

  mont_mul_ctrl #(.K(KS)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_m         (in_m),
    .result       (result),
    .done         (done),
    .add_start    (add_start),
    .add_subtract (add_subtract),
    .add_shift    (add_shift),
    .add_in_a     (add_in_a),
    .add_in_b     (add_in_b),
    .add_result   (add_result),
    .add_done     (add_done)
  );

  mont_mul_ctrl #(.K(KW)) u_dut_w (
    .clk          (clk),
    .reset        (reset),
    .start        (w_start),
    .in_a         (w_in_a),
    .in_b         (w_in_b),
    .in_m         (w_in_m),
    .result       (w_result),
    .done         (w_done),
    .add_start    (w_add_start),
    .add_subtract (w_add_subtract),
    .add_shift    (w_add_shift),
    .add_in_a     (w_add_in_a),
    .add_in_b     (w_add_in_b),
    .add_result   (w_add_result),
    .add_done     (w_add_done)
  );

  // Behavioural adders: capture operands on add_start, answer L cycles later.
  logic [ADD_W-1:0] s_a, s_b, ws_a, ws_b;
  logic             s_sub, ws_sub;
  int               s_cnt = 0, ws_cnt = 0;

  always @(posedge clk) begin
    if (reset) s_cnt <= 0;
    else if (add_start) begin
      s_a <= add_in_a; s_b <= add_in_b; s_sub <= add_subtract; s_cnt <= L;
    end else if (s_cnt > 0) s_cnt <= s_cnt - 1;
  end
  assign add_done   = (s_cnt == 1);
  assign add_result = s_sub ? ({1'b0, s_a} + {1'b0, ~s_b} + 515'd1) : ({1'b0, s_a} + {1'b0, s_b});

  always @(posedge clk) begin
    if (reset) ws_cnt <= 0;
    else if (w_add_start) begin
      ws_a <= w_add_in_a; ws_b <= w_add_in_b; ws_sub <= w_add_subtract; ws_cnt <= L;
    end else if (ws_cnt > 0) ws_cnt <= ws_cnt - 1;
  end
  assign w_add_done   = (ws_cnt == 1);
  assign w_add_result = ws_sub ? ({1'b0, ws_a} + {1'b0, ~ws_b} + 515'd1)
                               : ({1'b0, ws_a} + {1'b0, ws_b});

  // Event counters and final-subtract carry observed at the adder port.
  int   n_starts = 0, n_done = 0, w_n_starts = 0;
  logic last_carry = 1'b0;
  always @(posedge clk) begin
    if (add_start) n_starts <= n_starts + 1;
    if (w_add_start) w_n_starts <= w_n_starts + 1;
    if (done) n_done <= n_done + 1;
    if (add_done && s_sub) last_carry <= add_result[ADD_RES_W-1];
  end

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [519:0] got, input logic [519:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Operands must not move while the adder is working on them.
  always @(negedge clk) begin
    if (add_done) begin
      check_eq("hold_a", 520'(add_in_a), 520'(s_a));
      check_eq("hold_b", 520'(add_in_b), 520'(s_b));
      check_eq("hold_sub", 520'(add_subtract), 520'(s_sub));
    end
  end

  // a*b*2^-k mod m via modular halving for 2^-k (m odd) and plain wide arithmetic.
  function automatic logic [511:0] ref_mont(input logic [511:0] a, b, m, input int k);
    logic [1023:0] x, p, m1;
    m1 = 1024'(m);
    x  = 1024'(1);
    for (int j = 0; j < k; j++) x = x[0] ? (x + m1) >> 1 : x >> 1;
    p = (1024'(a) * 1024'(b)) % m1;
    p = (p * x) % m1;
    return p[511:0];
  endfunction

  // Expected start-to-done cycles and adder requests: each addition L+1 cycles when
  // issued, 1 when skipped; plus load, final subtraction and done cycles.
  function automatic void exp_cost(input logic [511:0] a, b, m, input int k,
                                   output int lat, output int starts);
    logic [513:0] c;
    logic         odd;
    c = '0; lat = 1; starts = 0;
    for (int j = 0; j < k; j++) begin
      if (a[j]) c = c + 514'(b);
      if (!TbSkip || a[j]) begin lat += L + 1; starts++; end else lat += 1;
      odd = c[0];
      if (odd) c = c + 514'(m);
      c = c >> 1;
      if (!TbSkip || odd) begin lat += L + 1; starts++; end else lat += 1;
    end
    lat += L + 2;
    starts++;
  endfunction

  task automatic run_small(input logic [KS-1:0] a, b, m, input bit disturb,
                           output logic [KS-1:0] res, output int lat, output int starts,
                           output int dones);
    int s0, d0;
    s0 = n_starts; d0 = n_done; lat = -1; res = '0;
    @(negedge clk);
    in_a = a; in_b = b; in_m = m; start = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin lat = n; res = result; break; end
      if (disturb && (n == 5 || n == 30)) begin
        in_a = 4'd5; in_b = 4'd7; start = 1'b1;
      end
    end
    @(negedge clk);
    starts = n_starts - s0;
    dones  = n_done - d0;
  endtask

  task automatic directed(input string tag, input logic [KS-1:0] a, b, m,
                          input logic [KS-1:0] exp_res, input bit chk_res, input bit disturb);
    logic [KS-1:0] r;
    int lat, st, dn, el, es;
    run_small(a, b, m, disturb, r, lat, st, dn);
    exp_cost(512'(a), 512'(b), 512'(m), KS, el, es);
    if (chk_res) check_eq({tag, "_res"}, 520'(r), 520'(exp_res));
    check_eq({tag, "_lat"}, 520'(lat), 520'(el));
    check_eq({tag, "_starts"}, 520'(st), 520'(es));
    check_eq({tag, "_dones"}, 520'(dn), 520'(1));
    check_eq({tag, "_pulse"}, 520'(done), 520'(0));
  endtask

  task automatic run_wide(input logic [KW-1:0] a, b, m);
    logic [KW-1:0] r;
    int lat, el, es, s0;
    lat = -1; r = '0; s0 = w_n_starts;
    @(negedge clk);
    w_in_a = a; w_in_b = b; w_in_m = m; w_start = 1'b1;
    for (int n = 1; n <= 6000; n++) begin
      @(negedge clk);
      w_start = 1'b0;
      if (w_done) begin lat = n; r = w_result; break; end
    end
    @(negedge clk);
    exp_cost(a, b, m, KW, el, es);
    check_eq("w_res", 520'(r), 520'(ref_mont(a, b, m, KW)));
    check_eq("w_lat", 520'(lat), 520'(el));
    check_eq("w_starts", 520'(w_n_starts - s0), 520'(es));
  endtask

  initial begin
    int unsigned   mi, ai, bi;
    logic [KW-1:0] wa, wb, wm;
    int            d0;

    reset = 1'b1; start = 1'b0; in_a = '0; in_b = '0; in_m = '0;
    w_start = 1'b0; w_in_a = '0; w_in_b = '0; w_in_m = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_done", 520'(done), 520'(0));
    check_eq("rst_add_start", 520'(add_start), 520'(0));
    check_eq("rst_sub", 520'(add_subtract), 520'(0));
    check_eq("rst_shift", 520'(add_shift), 520'(0));
    check_eq("rst_in_a", 520'(add_in_a), 520'(0));
    check_eq("rst_in_b", 520'(add_in_b), 520'(0));
    check_eq("rst_result", 520'(result), 520'(0));
    check_eq("rst_w_result", 520'(w_result), 520'(0));
    check_eq("rst_w_shift", 520'(w_add_shift), 520'(0));
    reset = 1'b0;

    directed("one", 4'd1, 4'd1, 4'd13, 4'd9, 1'b1, 1'b0);
    check_eq("one_carry", 520'(last_carry), 520'(0));
    directed("five_seven", 4'd5, 4'd7, 4'd13, 4'd3, 1'b1, 1'b0);
    directed("sub_taken", 4'd14, 4'd14, 4'd15, 4'd1, 1'b1, 1'b0);
    check_eq("sub_carry", 520'(last_carry), 520'(1));
    directed("a_zero", 4'd0, 4'd9, 4'd13, 4'd0, 1'b1, 1'b0);
    // Even modulus: result undefined, latency and single done still required.
    directed("even_m", 4'd3, 4'd5, 4'd8, 4'd0, 1'b0, 1'b0);
    directed("disturb", 4'd1, 4'd1, 4'd13, 4'd9, 1'b1, 1'b1);

    // Reset in the middle of an operation (result currently holds 9).
    @(negedge clk);
    in_a = 4'd1; in_b = 4'd1; in_m = 4'd13; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("abort_done", 520'(done), 520'(0));
    check_eq("abort_add_start", 520'(add_start), 520'(0));
    check_eq("abort_result", 520'(result), 520'(0));
    check_eq("abort_in_a", 520'(add_in_a), 520'(0));
    check_eq("abort_sub", 520'(add_subtract), 520'(0));
    reset = 1'b0;
    d0 = n_done;
    repeat (60) @(negedge clk);
    check_eq("abort_no_done", 520'(n_done - d0), 520'(0));
    directed("after_abort", 4'd1, 4'd1, 4'd13, 4'd9, 1'b1, 1'b0);

    for (int t = 0; t < 16; t++) begin
      mi = $urandom_range(7, 1) * 2 + 1;
      ai = $urandom_range(mi - 1, 0);
      bi = $urandom_range(mi - 1, 0);
      directed("rnd", 4'(ai), 4'(bi), 4'(mi),
               4'(ref_mont(512'(ai), 512'(bi), 512'(mi), KS)), 1'b1, 1'b0);
    end

    for (int t = 0; t < 2; t++) begin
      for (int j = 0; j < 16; j++) begin
        wa[j*32 +: 32] = $urandom;
        wb[j*32 +: 32] = $urandom;
        wm[j*32 +: 32] = $urandom;
      end
      wm[KW-1] = 1'b1;
      wm[0]    = 1'b1;
      wa = wa % wm;
      wb = wb % wm;
      run_wide(wa, wb, wm);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
